// File: rtl/perip_mmio_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perip_mmio_responder_pkg
// Description : Shared definitions for the MMIO peripheral responder:
//               register offsets, access-size encodings, scan default and
//               lane-enable helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package perip_mmio_responder_pkg;

    // Byte offsets of the registers inside the 64-byte window
    localparam logic [5:0] c_OFF_SEG  = 6'h00;
    localparam logic [5:0] c_OFF_DIP  = 6'h04;
    localparam logic [5:0] c_OFF_LED  = 6'h08;
    localparam logic [5:0] c_OFF_CTRL = 6'h0C;
    localparam logic [5:0] c_OFF_CNT  = 6'h10;

    // Default number of clk cycles each display digit stays lit
    localparam int c_SCAN_DIV_DEFAULT = 50000;

    // Access-size encodings carried on perip_mask
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } access_size_e;

    // Byte lanes touched by an access of the given size at the given address
    function automatic logic [3:0] lane_enables(input logic [1:0] mask,
                                                input logic [1:0] addr_lo);
        logic [3:0] be;
        case (access_size_e'(mask))
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replace only the enabled byte lanes of a register value
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decode
// Description : Combinational hex nibble to seven-segment decoder.
//               Output order is g..a, active-low (0 = segment lit).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_cathode
);

    // Lookup of the active-low segment pattern for each hex digit
    always_comb begin
        o_cathode = 7'h7F;
        case (i_nibble)
            4'h0: o_cathode = 7'h40;
            4'h1: o_cathode = 7'h79;
            4'h2: o_cathode = 7'h24;
            4'h3: o_cathode = 7'h30;
            4'h4: o_cathode = 7'h19;
            4'h5: o_cathode = 7'h12;
            4'h6: o_cathode = 7'h02;
            4'h7: o_cathode = 7'h78;
            4'h8: o_cathode = 7'h00;
            4'h9: o_cathode = 7'h10;
            4'hA: o_cathode = 7'h08;
            4'hB: o_cathode = 7'h03;
            4'hC: o_cathode = 7'h46;
            4'hD: o_cathode = 7'h21;
            4'hE: o_cathode = 7'h06;
            4'hF: o_cathode = 7'h0E;
            default: o_cathode = 7'h7F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/perip_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : perip_mmio_responder
// Description : MMIO slave with a 7-seg display register, DIP switch input,
//               LED register, control register and free-running cycle
//               counter. Reads return the whole register one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module perip_mmio_responder
    import perip_mmio_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8020_0000,
    parameter int          SCAN_DIV  = c_SCAN_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] perip_addr,
    input  logic [31:0] perip_wdata,
    input  logic        perip_wen,
    input  logic [1:0]  perip_mask,
    output logic [31:0] perip_rdata,
    input  logic [6:0]  DIP,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic [7:0]  led
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Registers
    logic [31:0]        r_seg;
    logic [7:0]         r_led;
    logic               r_run;
    logic [7:0]         r_dpmask;
    logic [31:0]        r_cnt;
    logic [6:0]         r_dip_s1;
    logic [6:0]         r_dip_s2;
    logic [31:0]        r_rdata;
    logic [c_PRE_W-1:0] r_pre;
    logic [2:0]         r_digit;
    logic [7:0]         r_anode;
    logic [6:0]         r_cathode;
    logic               r_dp;

    // Decode
    logic               w_hit;
    logic [5:0]         w_off;
    logic [3:0]         w_be;
    logic               w_wr;
    logic               w_seg_wr;
    logic               w_led_wr;
    logic               w_ctrl_wr;
    logic               w_clear;
    logic [31:0]        w_rd;
    logic               w_pre_wrap;
    logic [6:0]         w_digit_cathode;

    // Any address whose upper 26 bits match the base lies inside the window
    assign w_hit     = (perip_addr[31:6] == BASE_ADDR[31:6]);
    assign w_off     = {perip_addr[5:2], 2'b00};
    assign w_be      = lane_enables(perip_mask, perip_addr[1:0]);
    assign w_wr      = perip_wen & w_hit;
    assign w_seg_wr  = w_wr && (w_off == c_OFF_SEG);
    assign w_led_wr  = w_wr && (w_off == c_OFF_LED);
    assign w_ctrl_wr = w_wr && (w_off == c_OFF_CTRL);
    // Clear is a pulse carried by the write itself and never stored
    assign w_clear   = w_ctrl_wr & w_be[0] & perip_wdata[1];

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dip_s1 <= '0;
            r_dip_s2 <= '0;
        end else begin
            r_dip_s1 <= DIP;
            r_dip_s2 <= r_dip_s1;
        end
    end

    // Writable registers updated lane-by-lane on a write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg    <= '0;
            r_led    <= '0;
            r_run    <= 1'b0;
            r_dpmask <= '0;
        end else begin
            if (w_seg_wr) begin
                r_seg <= merge_lanes(r_seg, perip_wdata, w_be);
            end
            if (w_led_wr && w_be[0]) begin
                r_led <= perip_wdata[7:0];
            end
            if (w_ctrl_wr && w_be[0]) begin
                r_run <= perip_wdata[0];
            end
            if (w_ctrl_wr && w_be[1]) begin
                r_dpmask <= perip_wdata[15:8];
            end
        end
    end

    // Cycle counter; a clear in the same cycle overrides counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
        end else if (r_run) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Read mux sees register contents from before any same-cycle write
    always_comb begin
        w_rd = '0;
        if (w_hit) begin
            case (w_off)
                c_OFF_SEG:  w_rd = r_seg;
                c_OFF_DIP:  w_rd = {25'd0, r_dip_s2};
                c_OFF_LED:  w_rd = {24'd0, r_led};
                c_OFF_CTRL: w_rd = {16'd0, r_dpmask, 7'd0, r_run};
                c_OFF_CNT:  w_rd = r_cnt;
                default:    w_rd = '0;
            endcase
        end
    end

    // Read data is registered, giving one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd;
        end
    end

    assign w_pre_wrap = (r_pre == c_PRE_W'(SCAN_DIV - 1));

    // Prescaler and digit index for display multiplexing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_digit <= '0;
        end else if (w_pre_wrap) begin
            r_pre   <= '0;
            r_digit <= r_digit + 3'd1;
        end else begin
            r_pre   <= r_pre + c_PRE_W'(1);
        end
    end

    seg_hex_decode u_seg_hex_decode (
        .i_nibble  (r_seg[4*r_digit +: 4]),
        .o_cathode (w_digit_cathode)
    );

    // Registered display drive for the currently selected digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode   <= 8'hFE;
            r_cathode <= 7'h40;
            r_dp      <= 1'b1;
        end else begin
            r_anode   <= ~(8'b0000_0001 << r_digit);
            r_cathode <= w_digit_cathode;
            r_dp      <= ~r_dpmask[r_digit];
        end
    end

    assign perip_rdata = r_rdata;
    assign anode       = r_anode;
    assign cathode     = r_cathode;
    assign dp          = r_dp;
    assign led         = r_led;

endmodule
`default_nettype wire

// File: tb/tb_perip_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_perip_mmio_responder
// Description : Self-checking bench for perip_mmio_responder: vector table
//               for bus accesses plus sequences for counter, DIP, reset and
//               display scanning.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perip_mmio_responder;

    localparam logic [31:0] B = 32'h8020_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] perip_addr;
    logic [31:0] perip_wdata;
    logic        perip_wen;
    logic [1:0]  perip_mask;
    logic [31:0] perip_rdata;
    logic [6:0]  DIP;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic [7:0]  led;

    int n_chk;
    int n_fail;

    perip_mmio_responder #(
        .BASE_ADDR (B),
        .SCAN_DIV  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .perip_addr  (perip_addr),
        .perip_wdata (perip_wdata),
        .perip_wen   (perip_wen),
        .perip_mask  (perip_mask),
        .perip_rdata (perip_rdata),
        .DIP         (DIP),
        .anode       (anode),
        .cathode     (cathode),
        .dp          (dp),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mask;
        logic        chk;
        logic [31:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t tbl[29];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sample 1 time unit after posedge
    task automatic bus(input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] mask);
        @(negedge clk);
        perip_wen   = wen;
        perip_addr  = addr;
        perip_wdata = wdata;
        perip_mask  = mask;
        @(posedge clk);
        #1;
        perip_wen = 1'b0;
    endtask

    initial begin
        int d;
        n_chk  = 0;
        n_fail = 0;

        //         wen   addr          wdata          mask  chk   exp_rd         led
        tbl[0]  = '{1'b1, B+32'h00, 32'h1234_5678, 2'b10, 1'b0, 32'h0,         8'h00};
        tbl[1]  = '{1'b0, B+32'h00, 32'h0,         2'b10, 1'b1, 32'h1234_5678, 8'h00};
        tbl[2]  = '{1'b1, B+32'h0A, 32'h00AB_0000, 2'b00, 1'b0, 32'h0,         8'h00};
        tbl[3]  = '{1'b1, B+32'h08, 32'h0000_005A, 2'b00, 1'b0, 32'h0,         8'h5A};
        tbl[4]  = '{1'b0, B+32'h08, 32'h0,         2'b10, 1'b1, 32'h0000_005A, 8'h5A};
        tbl[5]  = '{1'b1, B+32'h02, 32'hBEEF_0000, 2'b01, 1'b0, 32'h0,         8'h5A};
        tbl[6]  = '{1'b0, B+32'h00, 32'h0,         2'b10, 1'b1, 32'hBEEF_5678, 8'h5A};
        tbl[7]  = '{1'b1, B+32'h01, 32'h0000_CD00, 2'b00, 1'b0, 32'h0,         8'h5A};
        tbl[8]  = '{1'b0, B+32'h00, 32'h0,         2'b10, 1'b1, 32'hBEEF_CD78, 8'h5A};
        tbl[9]  = '{1'b1, B+32'h03, 32'h7700_0000, 2'b00, 1'b0, 32'h0,         8'h5A};
        tbl[10] = '{1'b0, B+32'h00, 32'h0,         2'b00, 1'b1, 32'h77EF_CD78, 8'h5A};
        tbl[11] = '{1'b1, B+32'h08, 32'hFFFF_FF11, 2'b11, 1'b0, 32'h0,         8'h11};
        tbl[12] = '{1'b0, B+32'h08, 32'h0,         2'b01, 1'b1, 32'h0000_0011, 8'h11};
        tbl[13] = '{1'b1, B+32'h40, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         8'h11};
        tbl[14] = '{1'b0, B+32'h00, 32'h0,         2'b10, 1'b1, 32'h77EF_CD78, 8'h11};
        tbl[15] = '{1'b0, B+32'h40, 32'h0,         2'b10, 1'b1, 32'h0,         8'h11};
        tbl[16] = '{1'b0, B+32'h20, 32'h0,         2'b10, 1'b1, 32'h0,         8'h11};
        tbl[17] = '{1'b1, B+32'h14, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0,         8'h11};
        tbl[18] = '{1'b0, B+32'h14, 32'h0,         2'b10, 1'b1, 32'h0,         8'h11};
        tbl[19] = '{1'b1, B+32'h0C, 32'h0000_A500, 2'b10, 1'b0, 32'h0,         8'h11};
        tbl[20] = '{1'b0, B+32'h0C, 32'h0,         2'b10, 1'b1, 32'h0000_A500, 8'h11};
        tbl[21] = '{1'b1, B+32'h0D, 32'h0000_3C00, 2'b00, 1'b0, 32'h0,         8'h11};
        tbl[22] = '{1'b0, B+32'h0C, 32'h0,         2'b10, 1'b1, 32'h0000_3C00, 8'h11};
        tbl[23] = '{1'b1, B+32'h10, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0,         8'h11};
        tbl[24] = '{1'b0, B+32'h10, 32'h0,         2'b10, 1'b1, 32'h0,         8'h11};
        tbl[25] = '{1'b1, B+32'h00, 32'h0000_AAAA, 2'b01, 1'b0, 32'h0,         8'h11};
        tbl[26] = '{1'b0, B+32'h00, 32'h0,         2'b00, 1'b1, 32'h77EF_AAAA, 8'h11};
        tbl[27] = '{1'b1, 32'h0020_0008, 32'h0000_00FF, 2'b10, 1'b0, 32'h0,    8'h11};
        tbl[28] = '{1'b0, B+32'h08, 32'h0,         2'b10, 1'b1, 32'h0000_0011, 8'h11};

        // Reset state
        rst_n       = 1'b0;
        perip_wen   = 1'b0;
        perip_addr  = '0;
        perip_wdata = '0;
        perip_mask  = 2'b10;
        DIP         = 7'h00;
        #23;
        check("reset_rdata",   perip_rdata,      32'h0);
        check("reset_anode",   {24'd0, anode},   32'hFE);
        check("reset_cathode", {25'd0, cathode}, 32'h40);
        check("reset_dp",      {31'd0, dp},      32'h1);
        check("reset_led",     {24'd0, led},     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of bus accesses
        for (int i = 0; i < 29; i++) begin
            bus(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].mask);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_rdata", i), perip_rdata, tbl[i].exp_rd);
            end
            check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, tbl[i].exp_led});
        end

        // DIP synchronisation and read-only behaviour
        DIP = 7'h55;
        bus(1'b0, B+32'h04, 32'h0, 2'b10);
        bus(1'b0, B+32'h04, 32'h0, 2'b10);
        bus(1'b0, B+32'h04, 32'h0, 2'b10);
        check("dip_sync_3cyc", perip_rdata, 32'h55);
        bus(1'b1, B+32'h04, 32'h0000_0000, 2'b10);
        bus(1'b0, B+32'h04, 32'h0, 2'b10);
        check("dip_write_ignored", perip_rdata, 32'h55);

        // Count for exactly ten cycles of run=1
        bus(1'b1, B+32'h0C, 32'h1, 2'b10);
        for (int i = 0; i < 9; i++) begin
            bus(1'b0, B+32'h00, 32'h0, 2'b10);
        end
        bus(1'b1, B+32'h0C, 32'h0, 2'b10);
        bus(1'b0, B+32'h10, 32'h0, 2'b10);
        check("cnt_10", perip_rdata, 32'd10);
        bus(1'b0, B+32'h10, 32'h0, 2'b10);
        check("cnt_stopped", perip_rdata, 32'd10);

        // Wrap from a preloaded value
        bus(1'b1, B+32'h0C, 32'h1, 2'b10);
        force dut.r_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_cnt;
        bus(1'b0, B+32'h10, 32'h0, 2'b10);
        check("cnt_wrap_fffe", perip_rdata, 32'hFFFF_FFFE);
        bus(1'b0, B+32'h10, 32'h0, 2'b10);
        check("cnt_wrap_ffff", perip_rdata, 32'hFFFF_FFFF);
        bus(1'b0, B+32'h10, 32'h0, 2'b10);
        check("cnt_wrap_0", perip_rdata, 32'h0);

        // Clear while running
        bus(1'b1, B+32'h0C, 32'h3, 2'b10);
        bus(1'b0, B+32'h10, 32'h0, 2'b10);
        check("clear_cnt0", perip_rdata, 32'h0);
        bus(1'b0, B+32'h10, 32'h0, 2'b10);
        check("clear_cnt1", perip_rdata, 32'h1);
        bus(1'b0, B+32'h0C, 32'h0, 2'b10);
        check("clear_ctrl_rd", perip_rdata, 32'h1);

        // Reset in the middle of a read
        @(negedge clk);
        perip_addr = B + 32'h00;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_rdata",   perip_rdata,      32'h0);
        check("midrst_anode",   {24'd0, anode},   32'hFE);
        check("midrst_cathode", {25'd0, cathode}, 32'h40);
        check("midrst_dp",      {31'd0, dp},      32'h1);
        check("midrst_led",     {24'd0, led},     32'h0);

        // Scanning restarts at digit 0 after reset; edge n lights digit (n-1)/4
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            if (n == 1) begin
                perip_wen = 1'b1; perip_addr = B + 32'h00;
                perip_wdata = 32'h0000_00F0; perip_mask = 2'b10;
            end else if (n == 2) begin
                perip_wen = 1'b1; perip_addr = B + 32'h0C;
                perip_wdata = 32'h0000_0200; perip_mask = 2'b10;
            end else begin
                perip_wen = 1'b0;
            end
            @(posedge clk);
            #1;
            d = ((n - 1) / 4) % 8;
            check($sformatf("scan%0d_anode", n), {24'd0, anode},
                  {24'd0, ~(8'h01 << d)});
            check($sformatf("scan%0d_cathode", n), {25'd0, cathode},
                  (d == 1) ? 32'h0E : 32'h40);
            check($sformatf("scan%0d_dp", n), {31'd0, dp},
                  (d == 1) ? 32'h0 : 32'h1);
            @(negedge clk);
        end
        perip_wen = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perip_mmio_responder.md
PERIP_MMIO_RESPONDER -- requirements
Module: perip_mmio_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8020_0000, MMIO window base (64-byte window, 4-byte aligned registers).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clk cycles each seven-segment digit is lit.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port perip_addr, input, 32, byte address from CPU.
REQ-006 SHALL have port perip_wdata, input, 32, write data, lane-aligned to the address.
REQ-007 SHALL have port perip_wen, input, 1, write strobe, one write per high cycle.
REQ-008 SHALL have port perip_mask, input, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port perip_rdata, output, 32, registered read data.
REQ-010 SHALL have port DIP, input, 7, asynchronous switch inputs.
REQ-011 SHALL have port anode, output, 8, digit enables, active-low.
REQ-012 SHALL have port cathode, output, 7, segments g..a, active-low.
REQ-013 SHALL have port dp, output, 1, decimal point, active-low.
REQ-014 SHALL have port led, output, 8, LED register value.

Function
REQ-015 SHALL decode registers at these offsets: 0x00 SEG (RW, 8 hex nibbles, nibble i = digit i); 0x04 DIP (RO, bits[6:0]); 0x08 LED (RW, bits[7:0]); 0x0C CTRL (RW, bit0 run, bit1 clear self-clearing, bits[15:8] dp mask); 0x10 CNT (RO, 32-bit cycle counter).
REQ-016 SHALL present perip_rdata one clk after the address is sampled (1-cycle latency), whole 32-bit register, independent of perip_mask.
REQ-017 SHALL return 0 for reads of unmapped offsets or addresses outside the window.
REQ-018 SHALL ignore writes to RO, unmapped or out-of-window addresses.
REQ-019 SHALL apply byte writes to lane perip_addr[1:0] only, half writes to lanes selected by perip_addr[1], word writes to all lanes; other bits unchanged.
REQ-020 SHALL take effect of a write on the register at the clk edge where perip_wen is high; a read of the same register in the next cycle returns the new value.
REQ-021 SHALL synchronise DIP through two flops; DIP readback reflects a pin change within 3 cycles.
REQ-022 SHALL increment CNT by 1 per cycle while CTRL.run=1, wrapping 0xFFFF_FFFF -> 0.
REQ-023 SHALL, on a write with CTRL.clear=1, zero CNT on that edge; clear wins over run in the same cycle; counting resumes next cycle if run=1; clear reads back 0.
REQ-024 SHALL scan digits 0..7 cyclically via a prescaler counting 0..SCAN_DIV-1; digit index advances on prescaler wrap, 7 wraps to 0.
REQ-025 SHALL drive exactly one anode bit low (bit = digit index), cathode = hex pattern of SEG nibble, dp = ~CTRL.dpmask[index].
REQ-026 SHALL register anode/cathode/dp so a SEG write is visible no later than the next digit slot.

Reset
REQ-027 SHALL on rst_n low asynchronously clear SEG, LED, CTRL, CNT, prescaler, digit index, perip_rdata and DIP synchroniser to 0.
REQ-028 SHALL drive anode=8'hFE, cathode=7'h40 (digit "0"), dp=1, led=0 during reset.
REQ-029 SHALL, on reset mid-operation, discard any in-flight read and restart scanning at digit 0.

Structure
REQ-030 SHALL place register offsets, mask encodings and SCAN_DIV default in the shared define package.
REQ-031 SHALL instantiate one sub-module seg_hex_decode (4-bit nibble to 7 active-low segments, combinational).

Verification
REQ-032 SHALL check: word write 0x1234_5678 to SEG, read SEG -> 0x1234_5678 next cycle.
REQ-033 SHALL check: byte write 0xAB at BASE+0x0A (LED lane2) then byte 0x5A at BASE+0x08 -> led=8'h5A, LED read 0x0000_005A.
REQ-034 SHALL check: CTRL=1 for 10 cycles then CTRL=0 -> CNT reads 10; preload near wrap (run from 0xFFFF_FFFE via force) -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0.
REQ-035 SHALL check: CTRL write 0x3 while running -> CNT=0 that edge, 1 next cycle, CTRL reads 0x1.
REQ-036 SHALL check: SCAN_DIV=4, SEG=0x0000_00F0 -> anode FE,FD,... each 4 cycles; digit1 cathode=7'h0E ("F").
REQ-037 SHALL check: DIP=7'h55 -> DIP read 0x55 within 3 cycles; read of BASE+0x20 -> 0; write to DIP ignored.
